// File: rtl/output_classifier_pkg.sv
// Shared fixed-point word definition and classifier FSM encoding.
package output_classifier_pkg;

  localparam int unsigned INTEGER_WIDTH  = 8;
  localparam int unsigned FRACTION_WIDTH = 8;

  typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] fixed_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } classifier_state_t;

endpackage : output_classifier_pkg

// File: rtl/output_classifier.sv
// Argmax over the network output vector, presented on a valid/ready handshake.
module output_classifier #(
  parameter int unsigned NUM_OUTPUTS    = 10,
  parameter int unsigned INTEGER_WIDTH  = output_classifier_pkg::INTEGER_WIDTH,
  parameter int unsigned FRACTION_WIDTH = output_classifier_pkg::FRACTION_WIDTH,
  localparam int unsigned CLASS_WIDTH   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      outputs_ready,
  input  logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] outputs [NUM_OUTPUTS],
  output logic                                      busy,
  output logic                                      dropped,
  output logic                                      result_valid,
  input  logic                                      result_ready,
  output logic [CLASS_WIDTH-1:0]                    result_class,
  output logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] result_score
);

  import output_classifier_pkg::*;

  typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] word_t;

  localparam logic [CLASS_WIDTH-1:0] LAST_IDX = CLASS_WIDTH'(NUM_OUTPUTS - 1);

  classifier_state_t        state_q;
  word_t                    buf_q [NUM_OUTPUTS];
  word_t                    best_val_q;
  logic [CLASS_WIDTH-1:0]   best_idx_q;
  logic [CLASS_WIDTH-1:0]   idx_q;
  logic                     busy_q;
  logic                     dropped_q;
  logic                     valid_q;
  logic [CLASS_WIDTH-1:0]   class_q;
  word_t                    score_q;

  word_t                    cur_val;
  logic                     take_cur;
  logic                     handshake;
  logic                     capture;

  // Scan compare and capture/handshake decode.
  always_comb begin
    cur_val   = buf_q[idx_q];
    take_cur  = (cur_val > best_val_q);
    handshake = valid_q && result_ready;
    capture   = outputs_ready && ((state_q == IDLE) || ((state_q == HOLD) && handshake));
  end

  // Classifier FSM with registered outputs. result_valid rises one cycle after
  // HOLD is entered, giving a latency of NUM_OUTPUTS edges for every build.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      buf_q      <= '{default: '0};
      best_val_q <= '0;
      best_idx_q <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      dropped_q  <= 1'b0;
      valid_q    <= 1'b0;
      class_q    <= '0;
      score_q    <= '0;
    end else if (capture) begin
      buf_q      <= outputs;
      best_val_q <= outputs[0];
      best_idx_q <= '0;
      idx_q      <= CLASS_WIDTH'(1);
      busy_q     <= 1'b1;
      dropped_q  <= 1'b0;
      valid_q    <= 1'b0;
      if (NUM_OUTPUTS == 1) begin
        class_q <= '0;
        score_q <= outputs[0];
        state_q <= HOLD;
      end else begin
        state_q <= SCAN;
      end
    end else begin
      dropped_q <= outputs_ready && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
        end
        SCAN: begin
          if (take_cur) begin
            best_val_q <= cur_val;
            best_idx_q <= idx_q;
          end
          if (idx_q == LAST_IDX) begin
            class_q <= take_cur ? idx_q : best_idx_q;
            score_q <= take_cur ? cur_val : best_val_q;
            state_q <= HOLD;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        HOLD: begin
          if (handshake) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign dropped      = dropped_q;
  assign result_valid = valid_q;
  assign result_class = class_q;
  assign result_score = score_q;

endmodule : output_classifier

// File: tb/tb_output_classifier.sv
// Directed bench for output_classifier (NUM_OUTPUTS=10 and NUM_OUTPUTS=1 builds).
module tb_output_classifier;

  import output_classifier_pkg::*;

  logic       clock;
  logic       reset;

  logic       outputs_ready;
  fixed_t     vec [10];
  logic       busy, dropped, result_valid, result_ready;
  logic [3:0] result_class;
  fixed_t     result_score;

  logic       outputs_ready1;
  fixed_t     vec1 [1];
  logic       busy1, dropped1, result_valid1, result_ready1;
  logic [0:0] result_class1;
  fixed_t     result_score1;

  int checks   = 0;
  int failures = 0;

  output_classifier #(.NUM_OUTPUTS(10)) dut (
    .clock         (clock),
    .reset         (reset),
    .outputs_ready (outputs_ready),
    .outputs       (vec),
    .busy          (busy),
    .dropped       (dropped),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_class  (result_class),
    .result_score  (result_score)
  );

  output_classifier #(.NUM_OUTPUTS(1)) dut1 (
    .clock         (clock),
    .reset         (reset),
    .outputs_ready (outputs_ready1),
    .outputs       (vec1),
    .busy          (busy1),
    .dropped       (dropped1),
    .result_valid  (result_valid1),
    .result_ready  (result_ready1),
    .result_class  (result_class1),
    .result_score  (result_score1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input int v [10]);
    for (int i = 0; i < 10; i++) vec[i] = fixed_t'(v[i]);
  endtask

  initial begin
    int seen;

    reset          = 1'b0;
    outputs_ready  = 1'b1;
    result_ready   = 1'b0;
    outputs_ready1 = 1'b1;
    result_ready1  = 1'b0;
    vec1[0]        = fixed_t'(7);
    set_vec('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});

    // 1. Reset held with outputs_ready high
    repeat (3) tick();
    chk("rst_busy",    int'(busy), 0);
    chk("rst_dropped", int'(dropped), 0);
    chk("rst_valid",   int'(result_valid), 0);
    chk("rst_class",   int'(result_class), 0);
    chk("rst_score",   int'(result_score), 0);
    chk("rst_busy1",   int'(busy1), 0);
    reset          = 1'b1;
    outputs_ready  = 1'b0;
    outputs_ready1 = 1'b0;
    tick();
    chk("rst_nocap",   int'(busy), 0);

    // 2. Mixed vector, argmax at index 4
    set_vec('{5, -3, 7, 2, 9, 1, 0, -8, 4, 3});
    result_ready  = 1'b1;
    outputs_ready = 1'b1;
    tick();
    outputs_ready = 1'b0;
    set_vec('{100, 100, 100, 100, 100, 100, 100, 100, 100, 100});
    chk("t2_busy", int'(busy), 1);
    seen = 0;
    repeat (9) begin
      tick();
      if (result_valid) seen++;
    end
    chk("t2_early", seen, 0);
    tick();
    chk("t2_valid", int'(result_valid), 1);
    chk("t2_class", int'(result_class), 4);
    chk("t2_score", int'(result_score), 9);
    tick();
    chk("t2_onecyc", int'(result_valid), 0);
    chk("t2_idle",   int'(busy), 0);

    // 3. All negative with a tie
    set_vec('{-5, -2, -9, -2, -6, -4, -3, -8, -10, -7});
    outputs_ready = 1'b1;
    tick();
    outputs_ready = 1'b0;
    repeat (10) tick();
    chk("t3_valid", int'(result_valid), 1);
    chk("t3_class", int'(result_class), 1);
    chk("t3_score", int'(result_score), -2);
    tick();
    chk("t3_done",  int'(result_valid), 0);

    // 4. Backpressure with drops in SCAN and HOLD
    set_vec('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});
    result_ready  = 1'b0;
    outputs_ready = 1'b1;
    tick();
    for (int k = 1; k <= 20; k++) begin
      outputs_ready = (k == 3) || (k == 15);
      if (k == 15) set_vec('{50, 50, 50, 50, 50, 50, 50, 50, 50, 50});
      tick();
      if (k == 3)  chk("t4_drop_scan", int'(dropped), 1);
      if (k == 4)  chk("t4_drop_clr",  int'(dropped), 0);
      if (k == 15) begin
        chk("t4_drop_hold", int'(dropped), 1);
        chk("t4_hold_val",  int'(result_valid), 1);
      end
      if (k == 16) chk("t4_drop_one", int'(dropped), 0);
    end
    outputs_ready = 1'b0;
    chk("t4_valid", int'(result_valid), 1);
    chk("t4_class", int'(result_class), 9);
    chk("t4_score", int'(result_score), 10);
    result_ready = 1'b1;
    tick();
    chk("t4_hs_valid", int'(result_valid), 0);
    chk("t4_hs_busy",  int'(busy), 0);

    // 5. Back-to-back: new vector on the handshake edge
    set_vec('{0, -1, -2, -3, -4, -5, -6, -7, -8, -9});
    result_ready  = 1'b0;
    outputs_ready = 1'b1;
    tick();
    outputs_ready = 1'b0;
    repeat (10) tick();
    chk("t5a_valid", int'(result_valid), 1);
    chk("t5a_class", int'(result_class), 0);
    chk("t5a_score", int'(result_score), 0);
    set_vec('{4, 8, -1, 8, 2, 0, 0, 0, 0, 0});
    result_ready  = 1'b1;
    outputs_ready = 1'b1;
    tick();
    outputs_ready = 1'b0;
    chk("t5_drop_valid", int'(result_valid), 0);
    chk("t5_rescan",     int'(busy), 1);
    chk("t5_nodrop",     int'(dropped), 0);
    repeat (9) tick();
    chk("t5_early",  int'(result_valid), 0);
    tick();
    chk("t5b_valid", int'(result_valid), 1);
    chk("t5b_class", int'(result_class), 1);
    chk("t5b_score", int'(result_score), 8);
    tick();
    chk("t5b_done",  int'(result_valid), 0);

    // 6. Reset mid-SCAN, then NUM_OUTPUTS=1 build
    set_vec('{1, 1, 1, 1, 30, 1, 1, 1, 1, 1});
    outputs_ready = 1'b1;
    tick();
    outputs_ready = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t6_busy",  int'(busy), 0);
    chk("t6_score", int'(result_score), 0);
    seen = 0;
    repeat (15) begin
      tick();
      if (result_valid) seen++;
    end
    chk("t6_novalid", seen, 0);

    vec1[0]        = fixed_t'(-3);
    result_ready1  = 1'b0;
    outputs_ready1 = 1'b1;
    tick();
    outputs_ready1 = 1'b0;
    chk("n1_wait",  int'(result_valid1), 0);
    chk("n1_busy",  int'(busy1), 1);
    tick();
    chk("n1_valid", int'(result_valid1), 1);
    chk("n1_class", int'(result_class1), 0);
    chk("n1_score", int'(result_score1), -3);
    result_ready1 = 1'b1;
    tick();
    chk("n1_done",  int'(result_valid1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_output_classifier
